damage_calc: RTL and testbench

- Responder side of the core's damage handshake.
- On a one-cycle damageSCEN start pulse, walks every battlefront lane. In each lane it reads the player unit and the enemy unit from the unit table and applies simultaneous mutual damage using pre-damage stats. It writes the new HP values back, then holds damageCalcDone high until the next start.
- Sits between the top-level core FSM (initiator) and the unit-table RAM (1-cycle read latency).

---
 rtl/damage_pkg.sv | 23 ++
 rtl/damage_calc_if.sv | 48 ++++
 rtl/damage_alu.sv | 21 ++
 rtl/damage_calc.sv | 139 +++++++++++++
 tb/tb_damage_calc.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/damage_pkg.sv
// damage_pkg: shared types and constants for the damage block.
// State encodings, unit-word field positions and side selectors.
package damage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_P,
    RD_E,
    CALC,
    WR_P,
    WR_E,
    DONE
  } state_t;

  // Unit word is {ATK, DEF, HP}; a field sits at FLD*STAT_W.
  localparam int HP_FLD  = 0;
  localparam int DEF_FLD = 1;
  localparam int ATK_FLD = 2;

  localparam logic SIDE_PLAYER = 1'b0;
  localparam logic SIDE_ENEMY  = 1'b1;

endpackage

// File: rtl/damage_calc_if.sv
// damage_calc_if: core start/done handshake plus unit-table bus.
// slave = damage_calc view; master = core FSM and unit-table RAM.
interface damage_calc_if #(
  parameter int NUM_LANES = 4,
  parameter int STAT_W    = 8,
  parameter int ADDR_W    = 3
);

  localparam int KW = $clog2(NUM_LANES + 1);

  logic              damageSCEN;
  logic              damageCalcDone;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3*STAT_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [STAT_W-1:0] wr_hp;
  logic [KW-1:0]     playerKills;
  logic [KW-1:0]     enemyKills;

  modport slave (
    input  damageSCEN,
    input  rd_data,
    output damageCalcDone,
    output rd_en,
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_hp,
    output playerKills,
    output enemyKills
  );

  modport master (
    output damageSCEN,
    output rd_data,
    input  damageCalcDone,
    input  rd_en,
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_hp,
    input  playerKills,
    input  enemyKills
  );

endinterface

// File: rtl/damage_alu.sv
// damage_alu: one-direction saturating damage, combinational.
// Ports: atk (attacker), def/hp (target) -> hp_new, killed.
module damage_alu #(
  parameter int STAT_W = 8
) (
  input  logic [STAT_W-1:0] atk,
  input  logic [STAT_W-1:0] def,
  input  logic [STAT_W-1:0] hp,
  output logic [STAT_W-1:0] hp_new,
  output logic              killed
);

  logic [STAT_W-1:0] dmg;

  always_comb begin
    dmg    = (atk > def) ? atk - def : '0;
    hp_new = (hp > dmg) ? hp - dmg : '0;
    killed = (hp != '0) && (hp_new == '0);
  end

endmodule

// File: rtl/damage_calc.sv
// damage_calc: per-lane mutual damage pass over the unit table.
// Ports: clk, reset (sync, active-high), bus (damage_calc_if.slave).
module damage_calc #(
  parameter int NUM_LANES = 4,
  parameter int STAT_W    = 8,
  parameter int ADDR_W    = 3
) (
  input logic         clk,
  input logic         reset,
  damage_calc_if.slave bus
);

  import damage_pkg::*;

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int KW = $clog2(NUM_LANES + 1);
  localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

  state_t state, state_nx;

  logic [LW-1:0]       lane;
  logic [3*STAT_W-1:0] p_word;
  logic [STAT_W-1:0]   p_hp_new, e_hp_new;
  logic                engaged;
  logic [KW-1:0]       p_kills, e_kills;

  logic [STAT_W-1:0] p_atk, p_def, p_hp;
  logic [STAT_W-1:0] e_atk, e_def, e_hp;
  logic [STAT_W-1:0] p_new_c, e_new_c;
  logic              p_kill_c, e_kill_c, eng_c;
  logic              start;

  // Player word is held; enemy word is used straight off rd_data in CALC.
  assign p_atk = p_word[ATK_FLD*STAT_W +: STAT_W];
  assign p_def = p_word[DEF_FLD*STAT_W +: STAT_W];
  assign p_hp  = p_word[HP_FLD*STAT_W  +: STAT_W];
  assign e_atk = bus.rd_data[ATK_FLD*STAT_W +: STAT_W];
  assign e_def = bus.rd_data[DEF_FLD*STAT_W +: STAT_W];
  assign e_hp  = bus.rd_data[HP_FLD*STAT_W  +: STAT_W];

  assign eng_c = (p_hp != '0) && (e_hp != '0);
  assign start = bus.damageSCEN && (state == IDLE || state == DONE);

  damage_alu #(.STAT_W(STAT_W)) u_hit_enemy (
    .atk    (p_atk),
    .def    (e_def),
    .hp     (e_hp),
    .hp_new (e_new_c),
    .killed (e_kill_c)
  );

  damage_alu #(.STAT_W(STAT_W)) u_hit_player (
    .atk    (e_atk),
    .def    (p_def),
    .hp     (p_hp),
    .hp_new (p_new_c),
    .killed (p_kill_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lane     <= '0;
      p_word   <= '0;
      p_hp_new <= '0;
      e_hp_new <= '0;
      engaged  <= 1'b0;
      p_kills  <= '0;
      e_kills  <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        lane    <= '0;
        p_kills <= '0;
        e_kills <= '0;
      end
      if (state == RD_E) p_word <= bus.rd_data;
      if (state == CALC) begin
        p_hp_new <= p_new_c;
        e_hp_new <= e_new_c;
        engaged  <= eng_c;
        if (eng_c && e_kill_c) p_kills <= p_kills + KW'(1);
        if (eng_c && p_kill_c) e_kills <= e_kills + KW'(1);
      end
      if (state == WR_E && lane != LAST) lane <= lane + LW'(1);
    end
  end

  // Write strobes are also masked by reset so the reset edge never
  // commits a write from the cycle it lands in.
  always_comb begin
    state_nx           = state;
    bus.rd_en          = 1'b0;
    bus.rd_addr        = '0;
    bus.wr_en          = 1'b0;
    bus.wr_addr        = '0;
    bus.wr_hp          = '0;
    bus.damageCalcDone = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.damageSCEN) state_nx = RD_P;
      end
      RD_P: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'({lane, SIDE_PLAYER});
        state_nx    = RD_E;
      end
      RD_E: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'({lane, SIDE_ENEMY});
        state_nx    = CALC;
      end
      CALC: begin
        state_nx = WR_P;
      end
      WR_P: begin
        bus.wr_en   = engaged && !reset;
        bus.wr_addr = ADDR_W'({lane, SIDE_PLAYER});
        bus.wr_hp   = p_hp_new;
        state_nx    = WR_E;
      end
      WR_E: begin
        bus.wr_en   = engaged && !reset;
        bus.wr_addr = ADDR_W'({lane, SIDE_ENEMY});
        bus.wr_hp   = e_hp_new;
        state_nx    = (lane == LAST) ? DONE : RD_P;
      end
      DONE: begin
        bus.damageCalcDone = 1'b1;
        if (bus.damageSCEN) state_nx = RD_P;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.playerKills = p_kills;
  assign bus.enemyKills  = e_kills;

endmodule

// File: tb/tb_damage_calc.sv
// tb_damage_calc: unit-table RAM model plus per-lane damage model.
// Directed lane cases, random tables, ignored start, restart, reset.
module tb_damage_calc;

  localparam int NL = 4;
  localparam int SW = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] hp;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  damage_calc_if #(.NUM_LANES(NL), .STAT_W(SW), .ADDR_W(AW)) bus ();

  damage_calc #(.NUM_LANES(NL), .STAT_W(SW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [23:0] mem [8];
  logic [23:0] exp_tbl [8];
  wr_t log_q [$];
  wr_t exp_q [$];
  int exp_pk;
  int exp_ek;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (bus.wr_en) begin
      mem[bus.wr_addr][7:0] <= bus.wr_hp;
      log_q.push_back(wr_t'({8'(bus.wr_addr), bus.wr_hp}));
    end
  end

  function automatic logic [23:0] pack(int atk, int def, int hp);
    return {8'(atk), 8'(def), 8'(hp)};
  endfunction

  function automatic int hit(int atk, int def, int hp);
    int d;
    int h;
    d = atk - def;
    if (d < 0) d = 0;
    h = hp - d;
    if (h < 0) h = 0;
    return h;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = '0;
  endtask

  task automatic model_pass();
    exp_q.delete();
    exp_pk = 0;
    exp_ek = 0;
    for (int i = 0; i < 8; i++) exp_tbl[i] = mem[i];
    for (int l = 0; l < NL; l++) begin
      int pa, pd, ph, ea, ed, eh, np, ne;
      pa = int'(mem[2*l][23:16]);
      pd = int'(mem[2*l][15:8]);
      ph = int'(mem[2*l][7:0]);
      ea = int'(mem[2*l+1][23:16]);
      ed = int'(mem[2*l+1][15:8]);
      eh = int'(mem[2*l+1][7:0]);
      if (ph > 0 && eh > 0) begin
        np = hit(ea, pd, ph);
        ne = hit(pa, ed, eh);
        if (np == 0) exp_ek++;
        if (ne == 0) exp_pk++;
        exp_q.push_back(wr_t'({8'(2*l), 8'(np)}));
        exp_q.push_back(wr_t'({8'(2*l+1), 8'(ne)}));
        exp_tbl[2*l][7:0] = 8'(np);
        exp_tbl[2*l+1][7:0] = 8'(ne);
      end
    end
  endtask

  task automatic run_pass(input string name, input int pulse_at);
    int cnt;
    bit bad;
    model_pass();
    log_q.delete();
    @(negedge clk);
    bus.damageSCEN = 1'b1;
    @(negedge clk);
    bus.damageSCEN = 1'b0;
    cnt = 1;
    checks++;
    if ({bus.damageCalcDone, bus.playerKills, bus.enemyKills} !== 7'd0) begin
      failures++;
      $display("FAIL %s start_clear: done=%0b pk=%0d ek=%0d want 0 0 0",
               name, bus.damageCalcDone, bus.playerKills, bus.enemyKills);
    end
    while (!bus.damageCalcDone && cnt < 100) begin
      bus.damageSCEN = (cnt == pulse_at);
      @(negedge clk);
      cnt++;
    end
    bus.damageSCEN = 1'b0;
    checks++;
    if (cnt - 1 !== 20) begin
      failures++;
      $display("FAIL %s latency: got %0d want 20", name, cnt - 1);
    end
    checks++;
    bad = (log_q.size() != exp_q.size());
    for (int i = 0; i < log_q.size() && !bad; i++)
      if (log_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad) begin
      failures++;
      $display("FAIL %s writes: got %0d writes want %0d", name,
               log_q.size(), exp_q.size());
      for (int i = 0; i < log_q.size(); i++)
        $display("  got addr=%0d hp=%0d", log_q[i].addr, log_q[i].hp);
      for (int i = 0; i < exp_q.size(); i++)
        $display("  want addr=%0d hp=%0d", exp_q[i].addr, exp_q[i].hp);
    end
    checks++;
    if (int'(bus.playerKills) !== exp_pk || int'(bus.enemyKills) !== exp_ek) begin
      failures++;
      $display("FAIL %s kills: got pk=%0d ek=%0d want pk=%0d ek=%0d", name,
               bus.playerKills, bus.enemyKills, exp_pk, exp_ek);
    end
    checks++;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) if (mem[i] !== exp_tbl[i]) bad = 1'b1;
    if (bad) begin
      failures++;
      $display("FAIL %s table: contents differ from model", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.damageSCEN = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.damageCalcDone, bus.rd_en, bus.wr_en, bus.rd_addr,
           bus.wr_addr, bus.wr_hp, bus.playerKills, bus.enemyKills} !== '0) begin
        failures++;
        $display("FAIL reset_idle: cycle %0d done=%0b rd_en=%0b wr_en=%0b want 0",
                 i, bus.damageCalcDone, bus.rd_en, bus.wr_en);
      end
    end
  endtask

  task automatic test_basic();
    clear_mem();
    mem[0] = pack(10, 2, 20);
    mem[1] = pack(5, 3, 6);
    run_pass("basic", -1);
    checks++;
    if (mem[0][7:0] !== 8'd17 || mem[1][7:0] !== 8'd0 ||
        bus.playerKills !== 3'd1 || bus.enemyKills !== 3'd0) begin
      failures++;
      $display("FAIL basic_const: hp0=%0d hp1=%0d pk=%0d ek=%0d want 17 0 1 0",
               mem[0][7:0], mem[1][7:0], bus.playerKills, bus.enemyKills);
    end
  endtask

  task automatic test_def_ge_atk();
    clear_mem();
    mem[0] = pack(4, 9, 50);
    mem[1] = pack(3, 8, 50);
    run_pass("def_ge_atk", -1);
    checks++;
    if (mem[0][7:0] !== 8'd50 || mem[1][7:0] !== 8'd50 ||
        bus.playerKills !== 3'd0 || bus.enemyKills !== 3'd0) begin
      failures++;
      $display("FAIL def_ge_atk_const: hp0=%0d hp1=%0d pk=%0d ek=%0d want 50 50 0 0",
               mem[0][7:0], mem[1][7:0], bus.playerKills, bus.enemyKills);
    end
  endtask

  task automatic test_mutual_kill();
    clear_mem();
    mem[0] = pack(255, 0, 1);
    mem[1] = pack(255, 0, 1);
    run_pass("mutual_kill", -1);
    checks++;
    if (mem[0][7:0] !== 8'd0 || mem[1][7:0] !== 8'd0 ||
        bus.playerKills !== 3'd1 || bus.enemyKills !== 3'd1) begin
      failures++;
      $display("FAIL mutual_kill_const: hp0=%0d hp1=%0d pk=%0d ek=%0d want 0 0 1 1",
               mem[0][7:0], mem[1][7:0], bus.playerKills, bus.enemyKills);
    end
  endtask

  task automatic rand_table();
    for (int i = 0; i < 8; i++) begin
      int hp;
      hp = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0 && hp != 0) hp = int'($urandom_range(1, 12));
      mem[i] = pack(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), hp);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      rand_table();
      run_pass("random", -1);
    end
  endtask

  task automatic test_ignored_start();
    bit bad;
    rand_table();
    run_pass("ignored_start", 7);
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (!bus.damageCalcDone || bus.rd_en || bus.wr_en) bad = 1'b1;
    end
    checks++;
    if (bad || log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ignored_start_quiet: extra activity, writes=%0d want %0d",
               log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_restart();
    clear_mem();
    mem[4] = pack(255, 0, 1);
    mem[5] = pack(255, 0, 1);
    run_pass("restart_a", -1);
    rand_table();
    run_pass("restart_b", -1);
  endtask

  task automatic test_reset_mid_pass();
    clear_mem();
    mem[0] = pack(20, 5, 100);
    mem[1] = pack(15, 4, 100);
    mem[2] = pack(30, 1, 90);
    mem[3] = pack(25, 2, 90);
    log_q.delete();
    @(negedge clk);
    bus.damageSCEN = 1'b1;
    @(negedge clk);
    bus.damageSCEN = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd2) begin
      failures++;
      $display("FAIL mid_reset_setup: wr_en=%0b wr_addr=%0d want 1 2",
               bus.wr_en, bus.wr_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_strobe: wr_en=%0b want 0", bus.wr_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.damageCalcDone !== 1'b0 || bus.rd_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_edge: wr_en=%0b done=%0b rd_en=%0b want 0 0 0",
               bus.wr_en, bus.damageCalcDone, bus.rd_en);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.wr_en || bus.rd_en || bus.damageCalcDone) begin
        failures++;
        $display("FAIL mid_reset_idle: wr_en=%0b rd_en=%0b done=%0b want 0 0 0",
                 bus.wr_en, bus.rd_en, bus.damageCalcDone);
      end
    end
    checks++;
    if (log_q.size() != 2 || mem[2][7:0] !== 8'd90 || mem[3][7:0] !== 8'd90) begin
      failures++;
      $display("FAIL mid_reset_writes: writes=%0d hp2=%0d hp3=%0d want 2 90 90",
               log_q.size(), mem[2][7:0], mem[3][7:0]);
    end
    run_pass("after_reset", -1);
  endtask

  initial begin
    bus.damageSCEN = 1'b0;
    reset = 1'b1;
    clear_mem();
    test_reset();
    test_basic();
    test_def_ge_atk();
    test_mutual_kill();
    test_random();
    test_ignored_start();
    test_restart();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
